l1_repl: RTL and testbench
==========================

# l1_repl

Parametrised replacement manager for the L1 instruction and data caches. It sits beside the tag and data arrays in the two-stage lookup pipeline:
- **Read stage:** it reads per-set replacement state.
- **Analyze stage:** it takes valid, tag-compare and lock vectors and produces the hit flag, the selected way and the eviction flag.

It generalises the bit-MRU manager in four ways: configurable way and set counts, a selectable policy (bit-MRU or round-robin), invalid-first allocation with per-way locking, and a runtime re-initialisation request.

## Interface
Parameters:
- WAYS, 4: associativity, power of two, 2..16
- SETS, 256: number of sets, power of two; IDXW = clog2(SETS)
- MODE, 0: 0 = bit-MRU (state width STW = WAYS), 1 = round-robin pointer (STW = clog2(WAYS))

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req  in  1  lookup request, read stage
- idx  in  IDXW  set index of the request
- init_req  in  1  pulse; re-initialise all sets
- ready  out  1  block accepts req
- ld_val_vect  in  WAYS  line-valid per way, analyze stage
- tag_cmp_vect  in  WAYS  tag match per way, analyze stage
- lock_vect  in  WAYS  ways excluded from allocation, analyze stage
- hit  out  1  lookup hit
- evict_val  out  1  the selected way holds a valid line that will be evicted
- no_way  out  1  miss with every way locked
- way_vect  out  WAYS  one-hot selected way; zero when no_way

## Operation
**Init FSM (INIT, RUN)**
- Reset enters INIT with the sweep address at 0. Each INIT cycle writes state 0 to the current address and increments it.
- After address SETS-1 is written, the FSM moves to RUN.
- ready = (state == RUN).
- In RUN, init_req = 1 sends the FSM to INIT at the next edge with the sweep address at 0.

**Request acceptance**
- A request is accepted when req & ready & ~init_req. Accepted requests are registered as req_r and idx_r.
- If req and init_req are both high in the same cycle, init wins and the req is dropped.
- The requester must not assert req while ready = 0. Such a req is ignored.

**Analyze stage (combinational, while req_r = 1)**
- hit_vect = ld_val_vect & tag_cmp_vect.
- hit = req_r & |hit_vect. On a multi-hit, the lowest-index set bit is selected.
- If there is no hit and free = ~ld_val_vect & ~lock_vect is nonzero: way_vect = lowest set bit of free, and evict_val = 0.
- Otherwise, on a miss, the victim is chosen from the unlocked ways:
  - MODE 0: the lowest-index way with used bit = 0 and unlocked. If there is none, the lowest unlocked way.
  - MODE 1: the first unlocked way scanning upward from the pointer, wrapping at WAYS-1 to 0.
  - In either mode, evict_val = 1.
- If every way is locked on a miss: no_way = 1, way_vect = 0, evict_val = 0, and there is no state write.
- When req_r = 0, hit, evict_val, no_way and way_vect are all 0.

**State update (written at the end of the analyze cycle when req_r & ~no_way)**
- MODE 0:
  - upd = used | way_vect.
  - next = way_vect if (upd | lock_vect) is all ones, else upd.
  - The update applies on both hits and misses.
- MODE 1:
  - On a miss, next = (victim index + 1) mod WAYS.
  - On a hit, the state is unchanged and not written.

**Bypass**
- If an accepted request's idx equals idx_r while req_r = 1, the next analyze stage uses the registered next-state instead of the array output.
- This covers back-to-back requests to the same set.

## Timing
- **Reset:**
  - ready = 0 and req_r = 0; all outputs are 0.
  - ready rises SETS cycles after the first cycle with rst_n = 1.
  - Asserting rst_n low mid-sweep or mid-request discards the in-flight request and restarts INIT at address 0.
- **Latency:** req accepted in cycle t gives hit, way_vect, evict_val and no_way valid in cycle t+1. The state write happens at the edge ending t+1.
- **Throughput:** one request per cycle. Back-to-back requests to the same set are resolved by the bypass.
- **init_req with an in-flight request:** when init_req arrives in cycle t while req_r is analyzing, that request completes and writes at the end of cycle t. ready falls in cycle t+1.
- **Array timing:** the state array has a 1-cycle read latency. Its write port is shared between the init sweep and the update, which never coincide.

## Structure
- **Shared package l1_pkg:** L1_WAY_NUM, L1_SET_NUM, CORE_IDX_WIDTH, the replacement-mode constants (REPL_MRU = 0, REPL_RR = 1) and the FSM state encoding.
- **Storage:** the existing sram_dp, instantiated with WIDTH = STW and DEPTH = SETS.
- **Sub-module l1_repl_pick:** wrap-around find-first-set from a start index over a WAYS-bit mask, returning a one-hot result and a found flag. It is used for the free-way, MRU and round-robin selections; the lowest-bit searches use start index 0.

## Test plan
- **Reset/init:** WAYS = 4, SETS = 16, rst_n released → ready = 0 for 16 cycles and 1 on the 17th; a read of any set returns state 0.
- **MODE 0 saturation:** all ways valid, misses to set 3 → victims 0001, 0010, 0100, 1000; after the fourth miss the state equals 1000; the next miss selects 0001.
- **Invalid-first with lock:** ld_val_vect = 1011, lock_vect = 0100 on a miss → there is no free way, so the victim is chosen from unlocked ways 0, 1 and 3 with evict_val = 1. With lock_vect = 0000, way_vect = 0100 and evict_val = 0. With lock_vect = 1111, no_way = 1, way_vect = 0 and the state is unchanged.
- **MODE 1:** pointer 3, WAYS = 4, lock_vect = 0001, all ways valid, miss → way_vect = 1000 and the pointer becomes 0. The next miss skips locked way 0 and selects way_vect = 0010.
- **Bypass:** back-to-back requests to idx 5 in MODE 0, where the first is a miss allocating way 0 → the second request sees used = 0001 and selects 0010.
- **init_req mid-traffic:** init_req while a request is in analyze → that request's write completes; ready = 0 for SETS cycles; a req issued together with init_req is dropped; all sets read 0 afterwards.

Source files
------------

// File: rtl/l1_pkg.sv
// Shared L1 cache constants: geometry defaults, replacement modes and
// init FSM encoding.
package l1_pkg;

  localparam int unsigned L1_WAY_NUM     = 4;
  localparam int unsigned L1_SET_NUM     = 256;
  localparam int unsigned CORE_IDX_WIDTH = $clog2(L1_SET_NUM);

  localparam int unsigned REPL_MRU = 0;
  localparam int unsigned REPL_RR  = 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/l1_repl_if.sv
// Lookup-side bundle between the L1 pipeline and the replacement manager.
interface l1_repl_if
  import l1_pkg::*;
#(
  parameter int unsigned WAYS = L1_WAY_NUM,
  parameter int unsigned IDXW = CORE_IDX_WIDTH
);

  logic            req;
  logic [IDXW-1:0] idx;
  logic            init_req;
  logic            ready;
  logic [WAYS-1:0] ld_val_vect;
  logic [WAYS-1:0] tag_cmp_vect;
  logic [WAYS-1:0] lock_vect;
  logic            hit;
  logic            evict_val;
  logic            no_way;
  logic [WAYS-1:0] way_vect;

  modport master (
    output req, idx, init_req, ld_val_vect, tag_cmp_vect, lock_vect,
    input  ready, hit, evict_val, no_way, way_vect
  );

  modport slave (
    input  req, idx, init_req, ld_val_vect, tag_cmp_vect, lock_vect,
    output ready, hit, evict_val, no_way, way_vect
  );

endinterface

// File: rtl/l1_repl_pick.sv
// Wrap-around find-first-set: scans mask upward from start, returns one-hot.
module l1_repl_pick #(
  parameter int unsigned W  = 4,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic [W-1:0]  mask,
  input  logic [SW-1:0] start,
  output logic [W-1:0]  onehot,
  output logic          found
);

  logic [SW-1:0] pos;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned i = 0; i < W; i++) begin
      pos = start + SW'(i);
      if (!found && mask[pos]) begin
        onehot[pos] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_dp.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
module sram_dp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1_repl.sv
// L1 replacement manager: per-set bit-MRU or round-robin state, invalid-first
// allocation with way locking, and a sweeping re-initialisation FSM.
module l1_repl
  import l1_pkg::*;
#(
  parameter int unsigned WAYS = L1_WAY_NUM,
  parameter int unsigned SETS = L1_SET_NUM,
  parameter int unsigned MODE = REPL_MRU
) (
  input logic       clk,
  input logic       rst_n,
  l1_repl_if.slave  bus
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned WW   = $clog2(WAYS);
  localparam int unsigned STW  = (MODE == REPL_RR) ? WW : WAYS;

  logic [0:0]      fsm_q, fsm_d;
  logic [IDXW-1:0] addr_q, addr_d;
  logic            req_r_q, req_r_d;
  logic [IDXW-1:0] idx_r_q, idx_r_d;
  logic            byp_q, byp_d;
  logic [STW-1:0]  byp_st_q, byp_st_d;

  logic            ready_c, accept_c, in_init_c;
  logic [STW-1:0]  rd_st, cur, st_next;
  logic            upd_we;
  logic            mem_we;
  logic [IDXW-1:0] mem_waddr;
  logic [STW-1:0]  mem_wdata;

  logic [WAYS-1:0] hit_vect, free_vect, unl_vect;
  logic [WAYS-1:0] hit_oh, free_oh, vict_oh, victim_oh;
  logic            hit_found, free_found, vict_found;
  logic [WW-1:0]   vict_start;

  logic            hit_c, evict_c, nw_c;
  logic [WAYS-1:0] way_c;

  assign in_init_c = (fsm_q == ST_INIT);
  assign ready_c   = (fsm_q == ST_RUN);
  assign accept_c  = bus.req & ready_c & ~bus.init_req;

  // Init sweep / run FSM
  always_comb begin
    fsm_d  = fsm_q;
    addr_d = addr_q;
    case (fsm_q)
      ST_INIT: begin
        addr_d = addr_q + IDXW'(1);
        if (addr_q == IDXW'(SETS - 1)) fsm_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.init_req) begin
          fsm_d  = ST_INIT;
          addr_d = '0;
        end
      end
      default: fsm_d = ST_INIT;
    endcase
  end

  // Read-stage capture and same-set bypass of the pending state write
  always_comb begin
    req_r_d  = accept_c;
    idx_r_d  = accept_c ? bus.idx : idx_r_q;
    byp_d    = accept_c & req_r_q & (bus.idx == idx_r_q);
    byp_st_d = upd_we ? st_next : cur;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= ST_INIT;
      addr_q   <= '0;
      req_r_q  <= 1'b0;
      idx_r_q  <= '0;
      byp_q    <= 1'b0;
      byp_st_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      addr_q   <= addr_d;
      req_r_q  <= req_r_d;
      idx_r_q  <= idx_r_d;
      byp_q    <= byp_d;
      byp_st_q <= byp_st_d;
    end
  end

  // Write port is shared: sweep in INIT, state update in RUN
  assign mem_we    = in_init_c | upd_we;
  assign mem_waddr = in_init_c ? addr_q : idx_r_q;
  assign mem_wdata = in_init_c ? '0 : st_next;

  sram_dp #(
    .WIDTH (STW),
    .DEPTH (SETS)
  ) u_state (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (accept_c),
    .raddr (bus.idx),
    .rdata (rd_st)
  );

  assign cur       = byp_q ? byp_st_q : rd_st;
  assign hit_vect  = bus.ld_val_vect & bus.tag_cmp_vect;
  assign free_vect = ~bus.ld_val_vect & ~bus.lock_vect;
  assign unl_vect  = ~bus.lock_vect;

  l1_repl_pick #(.W(WAYS)) u_hit (
    .mask (hit_vect), .start ('0), .onehot (hit_oh), .found (hit_found)
  );

  l1_repl_pick #(.W(WAYS)) u_free (
    .mask (free_vect), .start ('0), .onehot (free_oh), .found (free_found)
  );

  l1_repl_pick #(.W(WAYS)) u_vict (
    .mask (unl_vect), .start (vict_start), .onehot (vict_oh), .found (vict_found)
  );

  generate
    if (MODE == REPL_RR) begin : g_rr
      logic [WW-1:0] way_idx;

      always_comb begin
        way_idx = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
          if (way_c[i]) way_idx = WW'(i);
        end
      end

      assign vict_start = cur;
      assign victim_oh  = vict_oh;
      assign st_next    = STW'(way_idx + WW'(1));
      assign upd_we     = req_r_q & ~hit_c & ~nw_c;
    end else begin : g_mru
      logic [WAYS-1:0] mru_oh, upd;
      logic            mru_found;

      l1_repl_pick #(.W(WAYS)) u_mru (
        .mask (~cur & unl_vect), .start ('0), .onehot (mru_oh), .found (mru_found)
      );

      // Saturated used bits restart from the way just touched
      assign upd        = cur | way_c;
      assign vict_start = '0;
      assign victim_oh  = mru_found ? mru_oh : vict_oh;
      assign st_next    = (&(upd | bus.lock_vect)) ? way_c : upd;
      assign upd_we     = req_r_q & ~nw_c;
    end
  endgenerate

  // Analyze-stage outputs
  always_comb begin
    hit_c   = 1'b0;
    evict_c = 1'b0;
    nw_c    = 1'b0;
    way_c   = '0;
    if (req_r_q) begin
      if (hit_found) begin
        hit_c = 1'b1;
        way_c = hit_oh;
      end else if (free_found) begin
        way_c = free_oh;
      end else if (vict_found) begin
        way_c   = victim_oh;
        evict_c = 1'b1;
      end else begin
        nw_c = 1'b1;
      end
    end
  end

  assign bus.ready     = ready_c;
  assign bus.hit       = hit_c;
  assign bus.evict_val = evict_c;
  assign bus.no_way    = nw_c;
  assign bus.way_vect  = way_c;

endmodule

// File: tb/tb_l1_repl.sv
// Directed bench for l1_repl: one bit-MRU and one round-robin instance
// (WAYS=4, SETS=16) driven with the same inputs, checked against hand values.
module tb_l1_repl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    int         dut;
    logic [3:0] idx;
    logic [3:0] ld;
    logic [3:0] tc;
    logic [3:0] lock;
    logic       hit;
    logic       evict;
    logic       nw;
    logic [3:0] way;
  } vec_t;

  vec_t vecs[26];

  l1_repl_if #(.WAYS(4), .IDXW(4)) if0 ();
  l1_repl_if #(.WAYS(4), .IDXW(4)) if1 ();

  l1_repl #(.WAYS(4), .SETS(16), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  l1_repl #(.WAYS(4), .SETS(16), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int d, logic [3:0] i, logic [3:0] l, logic [3:0] t, logic [3:0] k,
                              logic h, logic e, logic n, logic [3:0] w);
    vec_t v;
    v.dut = d; v.idx = i; v.ld = l; v.tc = t; v.lock = k;
    v.hit = h; v.evict = e; v.nw = n; v.way = w;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [3:0] i, input logic ini,
                        input logic [3:0] l, input logic [3:0] t, input logic [3:0] k);
    if0.req = r; if0.idx = i; if0.init_req = ini;
    if0.ld_val_vect = l; if0.tag_cmp_vect = t; if0.lock_vect = k;
    if1.req = r; if1.idx = i; if1.init_req = ini;
    if1.ld_val_vect = l; if1.tag_cmp_vect = t; if1.lock_vect = k;
  endtask

  function automatic logic [6:0] outs0();
    return {if0.hit, if0.evict_val, if0.no_way, if0.way_vect};
  endfunction

  function automatic logic [6:0] outs1();
    return {if1.hit, if1.evict_val, if1.no_way, if1.way_vect};
  endfunction

  // Counts negedges until ready is seen high on each instance (bounded)
  task automatic wait_ready(input string nm, input int exp);
    int k0 = -1;
    int k1 = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k0 < 0 && if0.ready === 1'b1) k0 = k;
      if (k1 < 0 && if1.ready === 1'b1) k1 = k;
      if (k0 >= 0 && k1 >= 0) break;
    end
    check({nm, "_dut0"}, k0, exp);
    check({nm, "_dut1"}, k1, exp);
  endtask

  // One isolated request: read stage, then analyze stage sampled mid-cycle
  task automatic apply(input vec_t v, input string nm);
    logic [6:0] act;
    @(posedge clk); #1;
    set_in(1'b1, v.idx, 1'b0, 4'h0, 4'h0, 4'h0);
    @(posedge clk); #1;
    set_in(1'b0, 4'h0, 1'b0, v.ld, v.tc, v.lock);
    @(negedge clk);
    act = (v.dut == 0) ? outs0() : outs1();
    check(nm, 32'(act), 32'({v.hit, v.evict, v.nw, v.way}));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_in(1'b1, 4'h0, 1'b0, 4'hF, 4'hF, 4'h0);

    // MODE 0 saturation on set 3, then a hit
    vecs[0]  = mk(0, 3, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001);
    vecs[1]  = mk(0, 3, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0010);
    vecs[2]  = mk(0, 3, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0100);
    vecs[3]  = mk(0, 3, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b1000);
    vecs[4]  = mk(0, 3, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001);
    vecs[5]  = mk(0, 3, 4'hF, 4'h4, 4'h0, 1, 0, 0, 4'b0100);
    // Invalid-first / locking on set 7 (MODE 0)
    vecs[6]  = mk(0, 7, 4'hB, 4'h0, 4'h4, 0, 1, 0, 4'b0001);
    vecs[7]  = mk(0, 7, 4'hB, 4'h0, 4'h0, 0, 0, 0, 4'b0100);
    vecs[8]  = mk(0, 7, 4'hB, 4'h0, 4'hF, 0, 0, 1, 4'b0000);
    vecs[9]  = mk(0, 7, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0010);
    vecs[10] = mk(0, 7, 4'hF, 4'h6, 4'h0, 1, 0, 0, 4'b0010);
    vecs[11] = mk(0, 7, 4'hF, 4'h0, 4'h8, 0, 1, 0, 4'b0001);
    vecs[12] = mk(0, 7, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0010);
    vecs[13] = mk(0, 7, 4'hF, 4'h8, 4'hF, 1, 0, 0, 4'b1000);
    vecs[14] = mk(0, 7, 4'h0, 4'hF, 4'h0, 0, 0, 0, 4'b0001);
    // Round-robin on set 9 (MODE 1)
    vecs[15] = mk(1, 9, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001);
    vecs[16] = mk(1, 9, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0010);
    vecs[17] = mk(1, 9, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0100);
    vecs[18] = mk(1, 9, 4'hF, 4'h0, 4'h1, 0, 1, 0, 4'b1000);
    vecs[19] = mk(1, 9, 4'hF, 4'h0, 4'h1, 0, 1, 0, 4'b0010);
    vecs[20] = mk(1, 9, 4'hF, 4'h1, 4'h0, 1, 0, 0, 4'b0001);
    vecs[21] = mk(1, 9, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0100);
    vecs[22] = mk(1, 9, 4'hF, 4'h0, 4'h8, 0, 1, 0, 4'b0001);
    vecs[23] = mk(1, 10, 4'hF, 4'h0, 4'hF, 0, 0, 1, 4'b0000);
    vecs[24] = mk(1, 10, 4'h7, 4'h0, 4'h0, 0, 0, 0, 4'b1000);
    vecs[25] = mk(1, 11, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {if1.ready, if0.ready}, 2'b00);
    check("reset_outs0", 32'(outs0()), 0);
    check("reset_outs1", 32'(outs1()), 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
    wait_ready("init_ready", 16);

    for (int n = 0; n < 26; n++) apply(vecs[n], $sformatf("vec%0d", n));

    // Back-to-back requests to set 5 exercise the bypass in both modes
    @(posedge clk); #1;
    set_in(1'b1, 4'h5, 1'b0, 4'hF, 4'h0, 4'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("byp_a0", 32'(outs0()), 32'(7'b0100001));
    check("byp_a1", 32'(outs1()), 32'(7'b0100001));
    @(posedge clk); #1;
    @(negedge clk);
    check("byp_b0", 32'(outs0()), 32'(7'b0100010));
    check("byp_b1", 32'(outs1()), 32'(7'b0100010));
    @(posedge clk); #1;
    if0.req = 1'b0; if1.req = 1'b0;
    @(negedge clk);
    check("byp_c0", 32'(outs0()), 32'(7'b0100100));
    check("byp_c1", 32'(outs1()), 32'(7'b0100100));

    // init_req while set 3 (used = 1101) is in analyze; a same-cycle req is dropped
    @(posedge clk); #1;
    set_in(1'b1, 4'h3, 1'b0, 4'hF, 4'h0, 4'h0);
    @(posedge clk); #1;
    set_in(1'b1, 4'h3, 1'b1, 4'hF, 4'h0, 4'h0);
    @(negedge clk);
    check("initreq_inflight", 32'(outs0()), 32'(7'b0100010));
    check("initreq_ready_hold", 32'(if0.ready), 1);
    @(posedge clk); #1;
    set_in(1'b0, 4'h0, 1'b0, 4'hF, 4'hF, 4'h0);
    @(negedge clk);
    check("initreq_dropped", 32'({outs1(), outs0()}), 0);
    check("initreq_ready_low", {if1.ready, if0.ready}, 2'b00);
    // this cycle was already the first low-ready cycle, so 15 remain
    wait_ready("reinit_ready", 15);

    apply(mk(0, 3, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001), "post_init_s3");
    apply(mk(0, 7, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001), "post_init_s7");
    apply(mk(1, 9, 4'hF, 4'h0, 4'h0, 0, 1, 0, 4'b0001), "post_init_s9");

    // Reset asserted while a request is in analyze
    @(posedge clk); #1;
    set_in(1'b1, 4'h2, 1'b0, 4'hF, 4'hF, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    if0.req = 1'b0; if1.req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_outs", 32'({outs1(), outs0()}), 0);
    check("rst_mid_ready", {if1.ready, if0.ready}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("rst_mid_reinit", 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
